// File: rtl/input_irq_controller.sv
// Round-robin interrupt arbiter for up to four byte-wide input devices.
// A granted byte and its source ID are held behind an Avalon-MM slave until the CPU reads DATA.
module input_irq_controller #(
   parameter int unsigned N_SRC = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_SRC-1:0]     src_irq,
   output logic [N_SRC-1:0]     src_read,
   input  logic [8*N_SRC-1:0]   src_readdata,
   input  logic [1:0]           avl_address,
   input  logic                 avl_read,
   input  logic                 avl_write,
   input  logic [7:0]           avl_writedata,
   output logic [7:0]           avl_readdata,
   output logic                 avl_irq
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [1:0]         grant_q, grant_d;
   logic               valid_q, valid_d;
   logic [1:0]         id_q, id_d;
   logic [7:0]         data_q, data_d;
   logic [N_SRC-1:0]   mask_q, mask_d;
   logic [N_SRC-1:0]   src_read_q, src_read_d;
   logic [7:0]         rdata_q, rdata_d;

   logic [N_SRC-1:0]   eligible;
   logic [7:0]         pending8;
   logic [1:0]         scan_idx;
   logic               scan_found;
   logic [7:0]         sel_byte;
   logic               data_rd;

   assign eligible = src_irq & mask_q;
   assign data_rd  = avl_read && (avl_address == 2'd1) && valid_q;

   always_comb begin
      pending8 = '0;
      pending8[N_SRC-1:0] = eligible;
   end

   // First eligible index at or above ptr, wrapping modulo N_SRC.
   always_comb begin
      int unsigned idx;
      scan_found = 1'b0;
      scan_idx   = ptr_q;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= N_SRC) idx = idx - N_SRC;
         if (!scan_found && eligible[idx]) begin
            scan_found = 1'b1;
            scan_idx   = 2'(idx);
         end
      end
   end

   always_comb begin
      sel_byte = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (grant_q == 2'(i)) sel_byte = src_readdata[8*i +: 8];
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      valid_d    = valid_q;
      id_d       = id_q;
      data_d     = data_q;
      mask_d     = mask_q;
      src_read_d = '0;
      rdata_d    = rdata_q;

      case (state_q)
         IDLE: begin
            if (scan_found) begin
               grant_d = scan_idx;
               for (int unsigned i = 0; i < N_SRC; i++) begin
                  src_read_d[i] = (scan_idx == 2'(i));
               end
               state_d = FETCH;
            end
         end
         FETCH: begin
            data_d  = sel_byte;
            id_d    = grant_q;
            valid_d = 1'b1;
            ptr_d   = (grant_q == 2'(N_SRC - 1)) ? 2'd0 : grant_q + 2'd1;
            state_d = HOLD;
         end
         HOLD: begin
            if (data_rd) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (avl_write && (avl_address == 2'd2)) mask_d = avl_writedata[N_SRC-1:0];

      if (avl_read) begin
         case (avl_address)
            2'd0:    rdata_d = {valid_q, 5'b0, id_q};
            2'd1:    rdata_d = data_q;
            2'd2:    rdata_d = 8'(mask_q);
            default: rdata_d = pending8;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         grant_q    <= '0;
         valid_q    <= 1'b0;
         id_q       <= '0;
         data_q     <= '0;
         mask_q     <= '0;
         src_read_q <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         valid_q    <= valid_d;
         id_q       <= id_d;
         data_q     <= data_d;
         mask_q     <= mask_d;
         src_read_q <= src_read_d;
         rdata_q    <= rdata_d;
      end
   end

   assign src_read     = src_read_q;
   assign avl_irq      = valid_q;
   assign avl_readdata = rdata_q;

endmodule
